// File: rtl/bus_seq_key_pkg.sv
// Shared types and helpers for the bus sequence-lock key.
//   state_t   : LOCKED / UNLOCKED sequence state
//   LFSR_TAPS : feedback mask for the 8-bit decoy LFSR
//   key_nib() : extract step k of a packed key sequence
package bus_seq_key_pkg;

  typedef enum logic {
    LOCKED   = 1'b0,
    UNLOCKED = 1'b1
  } state_t;

  // Taps 8,6,5,4 of a right-shifting register: stage 8 is bit 0 (the bit
  // shifting out), so stage t sits at bit index 8-t -> bits 0,2,3,4.
  localparam logic [7:0] LFSR_TAPS = 8'h1D;

  localparam int KEY_MAX_W = 256;  // 16 steps of up to 16-bit nibbles
  localparam int NIB_MAX_W = 16;

  function automatic logic [NIB_MAX_W-1:0] key_nib(input logic [KEY_MAX_W-1:0] key,
                                                   input int unsigned          k,
                                                   input int unsigned          nib_w);
    logic [KEY_MAX_W-1:0] sh;
    sh = key >> (k * nib_w);
    return NIB_MAX_W'(sh) & NIB_MAX_W'((1 << nib_w) - 1);
  endfunction

endpackage

// File: rtl/bus_seq_key_lfsr.sv
// 8-bit Fibonacci decoy LFSR, shifts right with feedback into bit 7.
//   clk, rst : clock, synchronous active-high reset (loads SEED)
//   i_adv    : advance one step this cycle
//   o_bit    : current bit 0 of the register
module bus_seq_key_lfsr
  import bus_seq_key_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hB5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_adv,
  output logic o_bit
);

  logic [7:0] r_lfsr;
  logic       w_fb;

  assign w_fb  = ^(r_lfsr & LFSR_TAPS);
  assign o_bit = r_lfsr[0];

  always_ff @(posedge clk) begin
    if (rst)        r_lfsr <= SEED;
    else if (i_adv) r_lfsr <= {w_fb, r_lfsr[7:1]};
  end

endmodule

// File: rtl/bus_seq_key.sv
// Bus-mapped sequence-lock key with serial ID readout.
// Qualified reads in the decoded window must present the key nibbles in
// order; once complete, each read shifts one ID bit out (LSB first). While
// locked, reads return decoy bits from an LFSR. Any in-window write relocks.
//   clk, rst  : clock, synchronous active-high reset
//   strobe    : one-cycle bus access pulse
//   ssel_n    : active-low slot select
//   br_w      : 1 = read, 0 = write
//   addr      : bus address (window decode + key nibble)
//   sdrd_o    : serial data bit (0 when not driven)
//   sdrd_oe   : drive enable, high during a qualified read
//   unlocked  : key sequence complete (registered)
//   step      : current match index (registered, debug)
module bus_seq_key
  import bus_seq_key_pkg::*;
#(
  parameter int                        ADDR_W    = 14,
  parameter logic [ADDR_W-1:0]         DEC_MASK  = 14'h3000,
  parameter logic [ADDR_W-1:0]         DEC_MATCH = 14'h1000,
  parameter int                        NIB_LSB   = 4,
  parameter int                        NIB_W     = 4,
  parameter int                        SEQ_LEN   = 4,
  parameter logic [SEQ_LEN*NIB_W-1:0]  KEY       = 16'hA9A2,
  parameter int                        ID_W      = 16,
  parameter logic [ID_W-1:0]           ID_VALUE  = 16'hC162,
  parameter logic [7:0]                LFSR_SEED = 8'hB5,
  parameter bit                        ONE_SHOT  = 1'b0,
  localparam int                       SW        = $clog2(SEQ_LEN + 1),
  localparam int                       PW        = (ID_W > 1) ? $clog2(ID_W) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strobe,
  input  logic              ssel_n,
  input  logic              br_w,
  input  logic [ADDR_W-1:0] addr,
  output logic              sdrd_o,
  output logic              sdrd_oe,
  output logic              unlocked,
  output logic [SW-1:0]     step
);

  if (SEQ_LEN < 1 || SEQ_LEN > 16) begin : g_bad_seq_len
    $error("bus_seq_key: SEQ_LEN must be 1..16");
  end
  if (LFSR_SEED == 8'h00) begin : g_bad_seed
    $error("bus_seq_key: LFSR_SEED must be nonzero");
  end

  state_t          r_state, w_state_nx;
  logic [SW-1:0]   r_step, w_step_nx;
  logic [PW-1:0]   r_bit_ptr, w_ptr_nx;

  logic             w_hit, w_rd_acc, w_wr_acc, w_lfsr_bit;
  logic [NIB_W-1:0] w_nib, w_key_cur, w_key0;

  assign w_hit    = strobe & ~ssel_n & ((addr & DEC_MASK) == DEC_MATCH);
  assign w_rd_acc = w_hit & br_w;
  assign w_wr_acc = w_hit & ~br_w;
  assign w_nib    = addr[NIB_LSB +: NIB_W];

  // In UNLOCKED the index runs past the key; the value is then unused.
  assign w_key_cur = NIB_W'(key_nib(KEY_MAX_W'(KEY), 32'(r_step), NIB_W));
  assign w_key0    = NIB_W'(key_nib(KEY_MAX_W'(KEY), 0, NIB_W));

  bus_seq_key_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .i_adv (w_rd_acc & (r_state == LOCKED)),
    .o_bit (w_lfsr_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= LOCKED;
      r_step    <= '0;
      r_bit_ptr <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_step    <= w_step_nx;
      r_bit_ptr <= w_ptr_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_step_nx  = r_step;
    w_ptr_nx   = r_bit_ptr;
    if (w_wr_acc) begin
      w_state_nx = LOCKED;
      w_step_nx  = '0;
      w_ptr_nx   = '0;
    end else if (w_rd_acc) begin
      if (r_state == UNLOCKED) begin
        if (r_bit_ptr == PW'(ID_W - 1)) begin
          w_ptr_nx = '0;
          if (ONE_SHOT) begin
            w_state_nx = LOCKED;
            w_step_nx  = '0;
          end
        end else begin
          w_ptr_nx = r_bit_ptr + 1'b1;
        end
      end else begin
        if (w_nib == w_key_cur) begin
          w_step_nx = r_step + 1'b1;
          if (r_step == SW'(SEQ_LEN - 1)) begin
            w_state_nx = UNLOCKED;
            w_ptr_nx   = '0;
          end
        end else if (w_nib == w_key0) begin
          // A miss that equals the first key nibble starts a fresh attempt.
          w_step_nx = SW'(1);
        end else begin
          w_step_nx = '0;
        end
      end
    end
  end

  // Output bit reflects state before this access's update.
  assign sdrd_oe  = w_rd_acc;
  assign sdrd_o   = w_rd_acc & ((r_state == UNLOCKED) ? ID_VALUE[r_bit_ptr] : w_lfsr_bit);
  assign unlocked = (r_state == UNLOCKED);
  assign step     = r_step;

endmodule

// File: tb/tb_bus_seq_key.sv
module tb_bus_seq_key;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strobe = 1'b0, ssel_n = 1'b1, br_w = 1'b1;
  logic [13:0] addr = '0;

  logic       so   [2];
  logic       soe  [2];
  logic       unl  [2];
  logic [2:0] stp  [2];

  always #5 clk = ~clk;

  // instance 0: ID wraps; instance 1: relock after last ID bit
  bus_seq_key #(.ONE_SHOT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .strobe(strobe), .ssel_n(ssel_n), .br_w(br_w), .addr(addr),
    .sdrd_o(so[0]), .sdrd_oe(soe[0]), .unlocked(unl[0]), .step(stp[0]));
  bus_seq_key #(.ONE_SHOT(1'b1)) u_once (
    .clk(clk), .rst(rst), .strobe(strobe), .ssel_n(ssel_n), .br_w(br_w), .addr(addr),
    .sdrd_o(so[1]), .sdrd_oe(soe[1]), .unlocked(unl[1]), .step(stp[1]));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  int          keyn [4] = '{2, 10, 9, 10};   // 16'hA9A2 split into nibbles, step 0 first
  logic [15:0] id_word  = 16'hC162;
  int          m_step [2];
  int          m_ptr  [2];
  bit          m_unl  [2];
  logic [7:0]  m_lfsr [2];
  bit          cur_nib_valid;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[4];
    return {fb, s[7:1]};
  endfunction

  function automatic bit in_hit();
    return strobe && !ssel_n && (addr[13:12] == 2'b01);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_step[i] = 0; m_ptr[i] = 0; m_unl[i] = 0; m_lfsr[i] = 8'hB5;
      end else if (in_hit()) begin
        if (!br_w) begin
          m_step[i] = 0; m_ptr[i] = 0; m_unl[i] = 0;
        end else if (m_unl[i]) begin
          if (m_ptr[i] == 15) begin
            m_ptr[i] = 0;
            if (i == 1) begin m_unl[i] = 0; m_step[i] = 0; end
          end else m_ptr[i]++;
        end else begin
          m_lfsr[i] = lfsr_next(m_lfsr[i]);
          if (int'(addr[7:4]) == keyn[m_step[i]]) begin
            m_step[i]++;
            if (m_step[i] == 4) begin m_unl[i] = 1; m_ptr[i] = 0; end
          end else if (int'(addr[7:4]) == keyn[0]) m_step[i] = 1;
          else m_step[i] = 0;
        end
      end
    end
  end

  // every-cycle compare against the model
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit eoe, eo;
      eoe = in_hit() && br_w;
      eo  = eoe && (m_unl[i] ? id_word[m_ptr[i]] : m_lfsr[i][0]);
      chk($sformatf("cyc_step%0d", i), int'(stp[i]), m_step[i]);
      chk($sformatf("cyc_unl%0d", i), int'(unl[i]), int'(m_unl[i]));
      chk($sformatf("cyc_oe%0d", i), int'(soe[i]), int'(eoe));
      chk($sformatf("cyc_o%0d", i), int'(so[i]), int'(eo));
    end
  end

  // ---------------- stimulus ----------------
  logic cap_o [2];
  logic cap_oe[2];

  // drive one cycle: inputs set now (just after an edge), outputs captured at negedge
  task automatic cyc(input bit stb, input bit rd, input int nib, input bit win,
                     input bit sel, input bit r);
    logic [3:0] lo, hi, n4;
    lo = 4'($urandom); hi = 4'($urandom); n4 = 4'(nib);
    strobe = stb; br_w = rd; ssel_n = ~sel; rst = r;
    addr = {(win ? 2'b01 : 2'(($urandom % 3) == 0 ? 0 : 2 + ($urandom % 2))), hi, n4, lo};
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin cap_o[i] = so[i]; cap_oe[i] = soe[i]; end
    @(posedge clk); #1;
    strobe = 1'b0; rst = 1'b0;
  endtask

  task automatic rd(input int nib); cyc(1, 1, nib, 1, 1, 0); endtask
  task automatic wr(input int nib); cyc(1, 0, nib, 1, 1, 0); endtask

  initial begin
    int seq1[4]   = '{2, 10, 9, 10};
    int dec4[4]   = '{1, 0, 1, 0};       // B5 -> DA -> 6D -> B6, bit 0 of each
    int idb [16]  = '{0,1,0,0,0,1,1,0,1,0,0,0,0,0,1,1};
    int seq3[6]   = '{2, 10, 2, 10, 9, 10};
    int stp3[6]   = '{1, 2, 1, 2, 3, 4};

    // reset
    cyc(0, 1, 0, 1, 1, 1);
    cyc(0, 1, 0, 1, 1, 1);
    for (int i = 0; i < 2; i++) begin
      chk("rst_step", int'(stp[i]), 0);
      chk("rst_unl", int'(unl[i]), 0);
      chk("rst_oe", int'(cap_oe[i]), 0);
      chk("rst_o", int'(cap_o[i]), 0);
    end

    // unlock with 2,A,9,A; decoy bits pinned from seed B5
    for (int k = 0; k < 4; k++) begin
      chk("seq_step_pre", int'(stp[0]), k);
      rd(seq1[k]);
      chk("seq_oe", int'(cap_oe[0]), 1);
      chk("seq_decoy", int'(cap_o[0]), dec4[k]);
    end
    chk("seq_step4", int'(stp[0]), 4);
    chk("seq_unl", int'(unl[0]), 1);
    chk("seq_unl_once", int'(unl[1]), 1);

    // ID readout 0xC162 LSB first, then wrap
    for (int k = 0; k < 16; k++) begin
      rd($urandom_range(0, 15));
      chk($sformatf("id_bit%0d", k), int'(cap_o[0]), idb[k]);
    end
    chk("once_relock", int'(unl[1]), 0);
    chk("once_step0", int'(stp[1]), 0);
    chk("wrap_still_unl", int'(unl[0]), 1);
    rd(5);
    chk("id_wrap_bit0", int'(cap_o[0]), 0);

    // restart on KEY[0] miss
    wr(0);
    chk("wr_relock", int'(unl[0]), 0);
    for (int k = 0; k < 6; k++) begin
      rd(seq3[k]);
      chk($sformatf("restart_step%0d", k), int'(stp[0]), stp3[k]);
    end
    chk("restart_unl", int'(unl[0]), 1);

    // write mid-sequence
    wr(2);
    rd(2); rd(10);
    chk("mid_step2", int'(stp[0]), 2);
    wr(9);
    chk("wr_oe", int'(cap_oe[0]), 0);
    chk("wr_step0", int'(stp[0]), 0);
    rd(9); rd(10);
    chk("wr_no_unl", int'(unl[0]), 0);

    // decoys after fresh reset, wrong nibble
    cyc(0, 1, 0, 1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      rd(5);
      chk("wrong_decoy", int'(cap_o[0]), dec4[k]);
      chk("wrong_step", int'(stp[0]), 0);
    end
    // deselected and out-of-window strobes: no effect
    rd(2);
    cyc(1, 1, 10, 1, 0, 0);
    chk("desel_oe", int'(cap_oe[0]), 0);
    chk("desel_step", int'(stp[0]), 1);
    cyc(1, 1, 10, 0, 1, 0);
    chk("outwin_oe", int'(cap_oe[0]), 0);
    chk("outwin_step", int'(stp[0]), 1);

    // rst mid-sequence beats a concurrent read
    cyc(0, 1, 0, 1, 1, 1);
    rd(2); rd(10); rd(9);
    chk("pre_rst_step3", int'(stp[0]), 3);
    cyc(1, 1, 10, 1, 1, 1);
    chk("rst_pri_step", int'(stp[0]), 0);
    chk("rst_pri_unl", int'(unl[0]), 0);

    // randomized traffic, biased toward completing the key
    for (int n = 0; n < 3000; n++) begin
      int r, nib;
      r = $urandom_range(0, 99);
      nib = ($urandom_range(0, 3) != 0) ? keyn[(m_step[0] < 4) ? m_step[0] : 0]
                                        : $urandom_range(0, 15);
      if (r < 1)       cyc(0, 1, 0, 1, 1, 1);
      else if (r < 75) cyc(1, $urandom_range(0, 11) != 0, nib,
                           $urandom_range(0, 9) != 0, $urandom_range(0, 15) != 0, 0);
      else             cyc(0, 1, nib, 1, 1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
